// File: rtl/vgalcd_pkg.sv
// Shared types and helpers for the vgalcd pixel unpacker: pixel formats,
// FSM states, bits-per-pixel / pixels-per-word lookup and RGB888 expansion.
package vgalcd_pkg;

  typedef enum logic [2:0] {
    MODE_RGB332   = 3'd0,
    MODE_RGB444   = 3'd1,
    MODE_RGB555   = 3'd2,
    MODE_RGB565   = 3'd3,
    MODE_XRGB8888 = 3'd4
  } vgalcd_mode_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFILL   = 3'd1,
    ST_SYNC      = 3'd2,
    ST_ACTIVE    = 3'd3,
    ST_UNDERFLOW = 3'd4
  } vgalcd_unpack_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } vgalcd_rgb_t;

  // log2 of bits per pixel; reserved modes unpack as 32 bpp and render black
  function automatic int unsigned bpp_log2(input vgalcd_mode_e mode);
    case (mode)
      MODE_RGB332:                          return 32'd3;
      MODE_RGB444, MODE_RGB555, MODE_RGB565: return 32'd4;
      default:                              return 32'd5;
    endcase
  endfunction

  // Pixels per bus word for a given format
  function automatic int unsigned ppw(input vgalcd_mode_e mode, input int unsigned data_width);
    return data_width >> bpp_log2(mode);
  endfunction

  function automatic logic [7:0] exp2(input logic [1:0] v);
    return {4{v}};
  endfunction

  function automatic logic [7:0] exp3(input logic [2:0] v);
    return {v, v, v[2:1]};
  endfunction

  function automatic logic [7:0] exp4(input logic [3:0] v);
    return {v, v};
  endfunction

  function automatic logic [7:0] exp5(input logic [4:0] v);
    return {v, v[4:2]};
  endfunction

  function automatic logic [7:0] exp6(input logic [5:0] v);
    return {v, v[5:4]};
  endfunction

  // Expand one raw pixel (right-aligned) to RGB888 by MSB replication
  function automatic vgalcd_rgb_t expand_pixel(input vgalcd_mode_e mode, input logic [23:0] pix);
    vgalcd_rgb_t rgb;
    rgb = '0;
    case (mode)
      MODE_RGB332: begin
        rgb.r = exp3(pix[7:5]);
        rgb.g = exp3(pix[4:2]);
        rgb.b = exp2(pix[1:0]);
      end
      MODE_RGB444: begin
        rgb.r = exp4(pix[11:8]);
        rgb.g = exp4(pix[7:4]);
        rgb.b = exp4(pix[3:0]);
      end
      MODE_RGB555: begin
        rgb.r = exp5(pix[14:10]);
        rgb.g = exp5(pix[9:5]);
        rgb.b = exp5(pix[4:0]);
      end
      MODE_RGB565: begin
        rgb.r = exp5(pix[15:11]);
        rgb.g = exp6(pix[10:5]);
        rgb.b = exp5(pix[4:0]);
      end
      MODE_XRGB8888: begin
        rgb.r = pix[23:16];
        rgb.g = pix[15:8];
        rgb.b = pix[7:0];
      end
      default: rgb = '0;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/vgalcd_unpack_fifo.sv
// Synchronous word FIFO with flush and occupancy output. Head word is
// presented combinationally; push and pop in the same cycle at full both
// succeed because the slot being written is the one being read out.
module vgalcd_unpack_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [DATA_WIDTH-1:0]      wdata_i,
  output logic [DATA_WIDTH-1:0]      head_c,
  output logic                       empty_c,
  output logic                       full_c,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  // Status flags and qualified push/pop
  always_comb begin
    empty_c = (level_o == '0);
    full_c  = (level_o == LVL_W'(DEPTH));
    pop_ok  = pop_i && !flush_i && !empty_c;
    push_ok = push_i && !flush_i && (!full_c || pop_ok);
    head_c  = mem[rd_ptr];
  end

  // Storage array
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= wdata_i;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_o <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_o <= level_o + LVL_W'(1);
        2'b01:   level_o <= level_o - LVL_W'(1);
        default: level_o <= level_o;
      endcase
    end
  end

endmodule

// File: rtl/vgalcd_pixel_unpack.sv
// vgalcd pixel-stream front end: buffers DMA words, unpacks 8/16/32-bpp
// pixels on each pixel-clock strobe and expands them to RGB888. Underflow
// drops the rest of the frame and resynchronises at the next frame end.
// Optional: define VGALCD_FILL_COLOR_EN to add fill_rgb_i, shown in place of
// black for active-area pixels while in SYNC or UNDERFLOW.
module vgalcd_pixel_unpack
  import vgalcd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned PREFILL_LVL = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          en_i,
  input  logic [2:0]                    mode_i,
  input  logic                          pclk_en_i,
  input  logic                          de_i,
  input  logic                          vend_i,
  input  logic                          pixel_valid_i,
  output logic                          pixel_ready_o,
  input  logic [DATA_WIDTH-1:0]         pixel_data_i,
`ifdef VGALCD_FILL_COLOR_EN
  input  logic [23:0]                   fill_rgb_i,
`endif
  output logic [7:0]                    r_o,
  output logic [7:0]                    g_o,
  output logic [7:0]                    b_o,
  output logic                          de_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          underflow_o,
  input  logic                          underflow_clr_i
);

  localparam int unsigned IDX_W = $clog2(DATA_WIDTH / 8);
  localparam int unsigned SH_W  = $clog2(DATA_WIDTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

  vgalcd_unpack_state_e  state;
  vgalcd_mode_e          frame_mode;
  logic [DATA_WIDTH-1:0] cur_word;
  logic [IDX_W-1:0]      idx;

  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  fifo_empty;
  logic                  fifo_full;

  logic                  strobe_c;
  logic                  last_pix_c;
  logic                  word_req_c;
  logic                  pop_c;
  logic                  push_c;
  logic                  flush_c;
  logic                  underflow_set_c;
  logic [SH_W-1:0]       shamt_c;
  logic [23:0]           pix_c;
  vgalcd_rgb_t           rgb_c;
  vgalcd_rgb_t           out_rgb_c;

  vgalcd_unpack_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_c),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .wdata_i (pixel_data_i),
    .head_c  (fifo_head),
    .empty_c (fifo_empty),
    .full_c  (fifo_full),
    .level_o (level_o)
  );

  // Word fetch, underflow detection and DMA handshake
  always_comb begin
    strobe_c   = (state == ST_ACTIVE) && pclk_en_i && de_i;
    last_pix_c = (idx == IDX_W'(ppw(frame_mode, DATA_WIDTH) - 32'd1));
    word_req_c = 1'b0;
    if (state == ST_SYNC && vend_i) word_req_c = 1'b1;
    if (state == ST_ACTIVE && (vend_i || (strobe_c && last_pix_c))) word_req_c = 1'b1;
    pop_c           = en_i && word_req_c && !fifo_empty;
    underflow_set_c = en_i && strobe_c && !vend_i && last_pix_c && fifo_empty;
    flush_c         = !en_i || (state == ST_UNDERFLOW);
    pixel_ready_o   = en_i && ((state == ST_UNDERFLOW) || !fifo_full || pop_c);
    push_c          = pixel_valid_i && pixel_ready_o && !flush_c;
  end

  // Current pixel extraction and the colour to present on the next strobe
  always_comb begin
    shamt_c   = SH_W'(32'(idx) << bpp_log2(frame_mode));
    pix_c     = 24'(cur_word >> shamt_c);
    rgb_c     = expand_pixel(frame_mode, pix_c);
    out_rgb_c = '0;
    if (de_i) begin
      if (state == ST_ACTIVE && en_i) begin
        out_rgb_c = rgb_c;
      end
`ifdef VGALCD_FILL_COLOR_EN
      else if (state == ST_UNDERFLOW || state == ST_SYNC) begin
        out_rgb_c = vgalcd_rgb_t'(fill_rgb_i);
      end
`endif
    end
  end

  // Control FSM, unpack state and registered outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= ST_IDLE;
      frame_mode  <= MODE_RGB332;
      cur_word    <= '0;
      idx         <= '0;
      r_o         <= '0;
      g_o         <= '0;
      b_o         <= '0;
      de_o        <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (pclk_en_i) begin
        r_o  <= out_rgb_c.r;
        g_o  <= out_rgb_c.g;
        b_o  <= out_rgb_c.b;
        de_o <= de_i;
      end

      if (underflow_set_c)      underflow_o <= 1'b1;
      else if (underflow_clr_i) underflow_o <= 1'b0;

      if (!en_i) begin
        state <= ST_IDLE;
        idx   <= '0;
      end else begin
        case (state)
          ST_IDLE: state <= ST_PREFILL;
          ST_PREFILL: begin
            if (level_o >= LVL_W'(PREFILL_LVL)) state <= ST_SYNC;
          end
          ST_SYNC: begin
            if (vend_i) begin
              cur_word   <= fifo_head;
              frame_mode <= vgalcd_mode_e'(mode_i);
              idx        <= '0;
              state      <= ST_ACTIVE;
            end
          end
          ST_ACTIVE: begin
            if (vend_i) begin
              idx        <= '0;
              frame_mode <= vgalcd_mode_e'(mode_i);
              if (fifo_empty) state <= ST_PREFILL;
              else            cur_word <= fifo_head;
            end else if (strobe_c) begin
              if (last_pix_c) begin
                idx <= '0;
                if (fifo_empty) state <= ST_UNDERFLOW;
                else            cur_word <= fifo_head;
              end else begin
                idx <= idx + IDX_W'(1);
              end
            end
          end
          ST_UNDERFLOW: begin
            if (vend_i) state <= ST_PREFILL;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vgalcd_pixel_unpack.sv
// Directed bench for vgalcd_pixel_unpack (DATA_WIDTH=64, FIFO_DEPTH=16, PREFILL_LVL=8).
module tb_vgalcd_pixel_unpack;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [2:0]  mode;
  logic        pclk_en;
  logic        de;
  logic        vend;
  logic        pvalid;
  logic        pready;
  logic [63:0] pdata;
  logic [7:0]  r, g, b;
  logic        deo;
  logic [4:0]  level;
  logic        uflow;
  logic        uclr;
`ifdef VGALCD_FILL_COLOR_EN
  logic [23:0] fill_rgb = 24'h000000;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vgalcd_pixel_unpack #(
    .DATA_WIDTH  (64),
    .FIFO_DEPTH  (16),
    .PREFILL_LVL (8)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .en_i            (en),
    .mode_i          (mode),
    .pclk_en_i       (pclk_en),
    .de_i            (de),
    .vend_i          (vend),
    .pixel_valid_i   (pvalid),
    .pixel_ready_o   (pready),
    .pixel_data_i    (pdata),
`ifdef VGALCD_FILL_COLOR_EN
    .fill_rgb_i      (fill_rgb),
`endif
    .r_o             (r),
    .g_o             (g),
    .b_o             (b),
    .de_o            (deo),
    .level_o         (level),
    .underflow_o     (uflow),
    .underflow_clr_i (uclr)
  );

  localparam logic [63:0] W565  = 64'h001F_07E0_F800_FFFF;
  localparam logic [63:0] W8888 = 64'hAA12_3456_00AB_CDEF;
  localparam logic [63:0] W8BR  = 64'h00FF_0000_0000_00FF;
  localparam logic [63:0] WUF   = 64'h0000_FF00_00FF_FFFF;
  localparam logic [63:0] WRS   = 64'h0011_2233_0044_5566;
  localparam logic [63:0] W332  = 64'h03E0_03E0_03E0_03E0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic d, input logic v);
    pclk_en = 1'b1;
    de      = d;
    vend    = v;
    tick();
    pclk_en = 1'b0;
    de      = 1'b0;
    vend    = 1'b0;
  endtask

  task automatic push_word(input logic [63:0] w);
    int n;
    n      = 0;
    pvalid = 1'b1;
    pdata  = w;
    #1;
    while (pready !== 1'b1 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 64) begin
      vectors++;
      miscompares++;
      $display("FAIL push_timeout: ready=%b required 1", pready);
    end
    @(posedge clk);
    #1;
    pvalid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    en      = 1'b0;
    mode    = 3'd0;
    pclk_en = 1'b0;
    de      = 1'b0;
    vend    = 1'b0;
    pvalid  = 1'b0;
    pdata   = '0;
    uclr    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  function automatic logic [23:0] pix_of(input int k);
    return 24'h100000 + 24'(k);
  endfunction

  function automatic logic [63:0] word_of(input int k);
    return {8'hA5, pix_of(2 * k + 1), 8'h5A, pix_of(2 * k)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 3'd0; pclk_en = 1'b0; de = 1'b0;
    vend = 1'b0; pvalid = 1'b0; pdata = '0; uclr = 1'b0;
    tick();
    vectors++; if ({r, g, b} !== 24'h0) begin miscompares++; $display("FAIL reset_rgb: got %h required 000000", {r, g, b}); end
    vectors++; if (deo !== 1'b0) begin miscompares++; $display("FAIL reset_de: got %b required 0", deo); end
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL reset_level: got %0d required 0", level); end
    vectors++; if (uflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow: got %b required 0", uflow); end
    vectors++; if (pready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b required 0", pready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rgb565();
    logic [23:0] exp_px [4];
    exp_px = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF};
    do_reset();
    en   = 1'b1;
    mode = 3'd3;
    push_word(W565); push_word(W565); push_word(W8888); push_word(W8BR);
    for (int i = 0; i < 4; i++) push_word(WUF);
    vectors++; if (level !== 5'd8) begin miscompares++; $display("FAIL 565_prefill_level: got %0d required 8", level); end
    tick();
    tick();
    strobe(1'b0, 1'b1);
    vectors++; if (level !== 5'd7) begin miscompares++; $display("FAIL 565_sync_pop: got %0d required 7", level); end
    vectors++; if ({r, g, b, deo} !== 25'h0) begin miscompares++; $display("FAIL 565_sync_out: got %h required 0000000", {r, g, b, deo}); end
    for (int i = 0; i < 4; i++) begin
      strobe(1'b1, 1'b0);
      vectors++; if ({r, g, b} !== exp_px[i]) begin miscompares++; $display("FAIL 565_px%0d: got %h required %h", i, {r, g, b}, exp_px[i]); end
      vectors++; if (deo !== 1'b1) begin miscompares++; $display("FAIL 565_de%0d: got %b required 1", i, deo); end
      if (i == 2) begin
        vectors++; if (level !== 5'd7) begin miscompares++; $display("FAIL 565_no_early_pop: got %0d required 7", level); end
      end
    end
    vectors++; if (level !== 5'd6) begin miscompares++; $display("FAIL 565_pop_last: got %0d required 6", level); end
    tick();
    vectors++; if ({r, g, b} !== 24'h0000FF) begin miscompares++; $display("FAIL 565_hold: got %h required 0000ff", {r, g, b}); end
  endtask

  task automatic test_mode_change();
    mode = 3'd4;
    strobe(1'b1, 1'b0);
    vectors++; if ({r, g, b} !== 24'hFFFFFF) begin miscompares++; $display("FAIL mode_still_565: got %h required ffffff", {r, g, b}); end
    strobe(1'b1, 1'b1);
    vectors++; if ({r, g, b} !== 24'hFF0000) begin miscompares++; $display("FAIL mode_vend_px: got %h required ff0000", {r, g, b}); end
    vectors++; if (level !== 5'd5) begin miscompares++; $display("FAIL mode_vend_pop: got %0d required 5", level); end
    strobe(1'b1, 1'b0);
    vectors++; if ({r, g, b} !== 24'hABCDEF) begin miscompares++; $display("FAIL 8888_px0: got %h required abcdef", {r, g, b}); end
    strobe(1'b1, 1'b0);
    vectors++; if ({r, g, b} !== 24'h123456) begin miscompares++; $display("FAIL 8888_px1: got %h required 123456", {r, g, b}); end
    vectors++; if (level !== 5'd4) begin miscompares++; $display("FAIL 8888_pop: got %0d required 4", level); end
    strobe(1'b1, 1'b0);
    vectors++; if ({r, g, b} !== 24'h0000FF) begin miscompares++; $display("FAIL 8888_px2: got %h required 0000ff", {r, g, b}); end
    strobe(1'b1, 1'b0);
    vectors++; if ({r, g, b} !== 24'hFF0000) begin miscompares++; $display("FAIL 8888_px3: got %h required ff0000", {r, g, b}); end
    vectors++; if (level !== 5'd3) begin miscompares++; $display("FAIL 8888_pop2: got %0d required 3", level); end
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 3; i++) begin
      strobe(1'b1, 1'b0);
      vectors++; if ({r, g, b} !== 24'hFFFFFF) begin miscompares++; $display("FAIL uf_drain_lo%0d: got %h required ffffff", i, {r, g, b}); end
      strobe(1'b1, 1'b0);
      vectors++; if ({r, g, b} !== 24'h00FF00) begin miscompares++; $display("FAIL uf_drain_hi%0d: got %h required 00ff00", i, {r, g, b}); end
      vectors++; if (level !== 5'(2 - i)) begin miscompares++; $display("FAIL uf_drain_level%0d: got %0d required %0d", i, level, 2 - i); end
    end
    strobe(1'b1, 1'b0);
    vectors++; if (uflow !== 1'b0) begin miscompares++; $display("FAIL uf_not_yet: got %b required 0", uflow); end
    uclr = 1'b1;
    strobe(1'b1, 1'b0);
    uclr = 1'b0;
    vectors++; if ({r, g, b} !== 24'h00FF00) begin miscompares++; $display("FAIL uf_last_px: got %h required 00ff00", {r, g, b}); end
    vectors++; if (uflow !== 1'b1) begin miscompares++; $display("FAIL uf_set_wins: got %b required 1", uflow); end
    strobe(1'b1, 1'b0);
    vectors++; if ({r, g, b, deo} !== 25'h1) begin miscompares++; $display("FAIL uf_black: got %h required 0000001", {r, g, b, deo}); end
    pvalid = 1'b1;
    pdata  = WUF;
    #1;
    vectors++; if (pready !== 1'b1) begin miscompares++; $display("FAIL uf_ready: got %b required 1", pready); end
    tick();
    pvalid = 1'b0;
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL uf_drop: got %0d required 0", level); end
    strobe(1'b0, 1'b1);
    vectors++; if (uflow !== 1'b1) begin miscompares++; $display("FAIL uf_sticky: got %b required 1", uflow); end
    uclr = 1'b1;
    tick();
    uclr = 1'b0;
    vectors++; if (uflow !== 1'b0) begin miscompares++; $display("FAIL uf_clear: got %b required 0", uflow); end
    for (int i = 0; i < 8; i++) push_word(WRS);
    vectors++; if (level !== 5'd8) begin miscompares++; $display("FAIL resync_level: got %0d required 8", level); end
    tick();
    tick();
    strobe(1'b0, 1'b1);
    vectors++; if (level !== 5'd7) begin miscompares++; $display("FAIL resync_pop: got %0d required 7", level); end
    strobe(1'b1, 1'b0);
    vectors++; if ({r, g, b} !== 24'h445566) begin miscompares++; $display("FAIL resync_px0: got %h required 445566", {r, g, b}); end
    strobe(1'b1, 1'b0);
    vectors++; if ({r, g, b} !== 24'h112233) begin miscompares++; $display("FAIL resync_px1: got %h required 112233", {r, g, b}); end
  endtask

  task automatic test_rgb332();
    logic [23:0] exp_rgb;
    do_reset();
    en   = 1'b1;
    mode = 3'd0;
    for (int i = 0; i < 8; i++) push_word(W332);
    tick();
    tick();
    strobe(1'b0, 1'b1);
    vectors++; if (level !== 5'd7) begin miscompares++; $display("FAIL 332_sync_pop: got %0d required 7", level); end
    for (int i = 0; i < 8; i++) begin
      strobe(1'b1, 1'b0);
      exp_rgb = (i % 2 == 0) ? 24'hFF0000 : 24'h0000FF;
      vectors++; if ({r, g, b} !== exp_rgb) begin miscompares++; $display("FAIL 332_px%0d: got %h required %h", i, {r, g, b}, exp_rgb); end
      if (i == 6) begin
        vectors++; if (level !== 5'd7) begin miscompares++; $display("FAIL 332_no_pop7: got %0d required 7", level); end
      end
    end
    vectors++; if (level !== 5'd6) begin miscompares++; $display("FAIL 332_pop8: got %0d required 6", level); end
  endtask

  task automatic test_en_drop();
    strobe(1'b1, 1'b0);
    vectors++; if ({r, g, b} !== 24'hFF0000) begin miscompares++; $display("FAIL en_pre_px: got %h required ff0000", {r, g, b}); end
    en = 1'b0;
    tick();
    vectors++; if (level !== 5'd0) begin miscompares++; $display("FAIL en_flush: got %0d required 0", level); end
    vectors++; if (pready !== 1'b0) begin miscompares++; $display("FAIL en_ready: got %b required 0", pready); end
    strobe(1'b1, 1'b0);
    vectors++; if ({r, g, b, deo} !== 25'h1) begin miscompares++; $display("FAIL en_idle_black: got %h required 0000001", {r, g, b, deo}); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] sb [$];
    logic [23:0] exp_rgb;
    logic        exp_rdy;
    int          next_w;
    do_reset();
    en   = 1'b1;
    mode = 3'd4;
    for (int k = 0; k < 16; k++) begin
      push_word(word_of(k));
      sb.push_back(pix_of(2 * k));
      sb.push_back(pix_of(2 * k + 1));
    end
    vectors++; if (level !== 5'd16) begin miscompares++; $display("FAIL b2b_full: got %0d required 16", level); end
    pvalid = 1'b1;
    pdata  = word_of(16);
    #1;
    vectors++; if (pready !== 1'b0) begin miscompares++; $display("FAIL b2b_full_ready: got %b required 0", pready); end
    pclk_en = 1'b1;
    vend    = 1'b1;
    #1;
    vectors++; if (pready !== 1'b1) begin miscompares++; $display("FAIL b2b_pop_ready: got %b required 1", pready); end
    tick();
    pclk_en = 1'b0;
    vend    = 1'b0;
    sb.push_back(pix_of(32));
    sb.push_back(pix_of(33));
    vectors++; if (level !== 5'd16) begin miscompares++; $display("FAIL b2b_level_sync: got %0d required 16", level); end
    next_w = 17;
    for (int i = 0; i < 12; i++) begin
      pdata   = word_of(next_w);
      pclk_en = 1'b1;
      de      = 1'b1;
      #1;
      exp_rdy = (i % 2 == 1);
      vectors++; if (pready !== exp_rdy) begin miscompares++; $display("FAIL b2b_ready%0d: got %b required %b", i, pready, exp_rdy); end
      tick();
      pclk_en = 1'b0;
      de      = 1'b0;
      if (exp_rdy) begin
        sb.push_back(pix_of(2 * next_w));
        sb.push_back(pix_of(2 * next_w + 1));
        next_w++;
      end
      exp_rgb = sb.pop_front();
      vectors++; if ({r, g, b} !== exp_rgb) begin miscompares++; $display("FAIL b2b_px%0d: got %h required %h", i, {r, g, b}, exp_rgb); end
      vectors++; if (level !== 5'd16) begin miscompares++; $display("FAIL b2b_level%0d: got %0d required 16", i, level); end
    end
    pvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rgb565();
    test_mode_change();
    test_underflow();
    test_rgb332();
    test_en_drop();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
